frame_ctrl: RTL and testbench

FRAME_CTRL -- requirements
Module: frame_ctrl

---
 rtl/frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_frame_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_ctrl.sv
// Per-frame controller: on each vsync edge it steps the player position,
// then writes one full wave profile (flat or ramp) into the wave buffer.
module frame_ctrl #(
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768,
    parameter int VPOS_STEP     = 100,
    parameter int VPOS_INIT     = 384,
    parameter int FLAT_LEVEL    = 384
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        up,
    input  logic        down,
    input  logic        disp_sel,
    output logic [10:0] p_offset,
    output logic [9:0]  p_vpos,
    output logic [9:0]  wave_index,
    output logic [9:0]  wave_data,
    output logic        wave_we,
    output logic        wave_ready,
    output logic        busy,
    output logic        frame_overrun
);

    localparam logic [10:0] OFFSET_MAX = 11'(SCREEN_WIDTH - 1);
    localparam logic [9:0]  INDEX_MAX  = 10'(SCREEN_WIDTH - 1);
    localparam logic [10:0] VPOS_MAX   = 11'(SCREEN_HEIGHT - 1);
    localparam logic [10:0] STEP       = 11'(VPOS_STEP);
    localparam logic [9:0]  VPOS_RST   = 10'(VPOS_INIT);
    localparam logic [9:0]  FLAT       = 10'(FLAT_LEVEL);

    typedef enum logic [1:0] {IDLE, UPDATE, FILL, DONE} state_t;

    state_t      state_reg, state_next;
    logic [10:0] p_offset_reg, p_offset_next;
    logic [9:0]  p_vpos_reg, p_vpos_next;
    logic [9:0]  wave_index_reg, wave_index_next;
    logic        sel_q_reg, sel_q_next;
    logic        wave_ready_reg, wave_ready_next;
    logic        overrun_reg, overrun_next;
    logic        up_pend_reg, up_pend_next;
    logic        down_pend_reg, down_pend_next;

    // Edge detectors: bit 0 vsync, bit 1 up, bit 2 down.
    logic [2:0] sync_in;
    logic [2:0] sync_rise;
    logic       vsync_rise, up_rise, down_rise;

    assign sync_in = {down, up, vsync};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            logic q_reg;
            always_ff @(posedge vclock) begin
                if (reset) begin
                    q_reg <= 1'b0;
                end else begin
                    q_reg <= sync_in[gi];
                end
            end
            assign sync_rise[gi] = sync_in[gi] & ~q_reg;
        end
    endgenerate

    assign vsync_rise = sync_rise[0];
    assign up_rise    = sync_rise[1];
    assign down_rise  = sync_rise[2];

    // Position step is evaluated at 11 bits so neither direction can wrap.
    logic [10:0] vpos_ext;
    logic [10:0] vpos_sum;
    logic [9:0]  vpos_stepped;

    always_comb begin
        vpos_ext     = {1'b0, p_vpos_reg};
        vpos_sum     = vpos_ext + STEP;
        vpos_stepped = p_vpos_reg;
        if (up_pend_reg && !down_pend_reg) begin
            vpos_stepped = (vpos_ext < STEP) ? 10'd0 : 10'(vpos_ext - STEP);
        end else if (down_pend_reg && !up_pend_reg) begin
            vpos_stepped = (vpos_sum > VPOS_MAX) ? 10'(VPOS_MAX) : 10'(vpos_sum);
        end
    end

    always_comb begin
        state_next      = state_reg;
        p_offset_next   = p_offset_reg;
        p_vpos_next     = p_vpos_reg;
        wave_index_next = wave_index_reg;
        sel_q_next      = sel_q_reg;
        wave_ready_next = wave_ready_reg;
        overrun_next    = overrun_reg | (vsync_rise && (state_reg != IDLE));
        up_pend_next    = up_pend_reg | up_rise;
        down_pend_next  = down_pend_reg | down_rise;

        case (state_reg)
            IDLE: begin
                if (vsync_rise) begin
                    state_next      = UPDATE;
                    wave_ready_next = 1'b0;
                end
            end
            UPDATE: begin
                state_next      = FILL;
                p_offset_next   = (p_offset_reg == OFFSET_MAX) ? 11'd0 : p_offset_reg + 11'd1;
                p_vpos_next     = vpos_stepped;
                // An edge landing in this very cycle belongs to the next frame.
                up_pend_next    = up_rise;
                down_pend_next  = down_rise;
                sel_q_next      = disp_sel;
                wave_index_next = 10'd0;
            end
            FILL: begin
                wave_index_next = wave_index_reg + 10'd1;
                if (wave_index_reg == INDEX_MAX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next      = IDLE;
                wave_ready_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            state_reg      <= IDLE;
            p_offset_reg   <= 11'd0;
            p_vpos_reg     <= VPOS_RST;
            wave_index_reg <= 10'd0;
            sel_q_reg      <= 1'b0;
            wave_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            up_pend_reg    <= 1'b0;
            down_pend_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            p_offset_reg   <= p_offset_next;
            p_vpos_reg     <= p_vpos_next;
            wave_index_reg <= wave_index_next;
            sel_q_reg      <= sel_q_next;
            wave_ready_reg <= wave_ready_next;
            overrun_reg    <= overrun_next;
            up_pend_reg    <= up_pend_next;
            down_pend_reg  <= down_pend_next;
        end
    end

    assign p_offset      = p_offset_reg;
    assign p_vpos        = p_vpos_reg;
    assign wave_index    = wave_index_reg;
    assign wave_data     = sel_q_reg ? (wave_index_reg + p_offset_reg[9:0]) : FLAT;
    assign wave_we       = (state_reg == FILL);
    assign wave_ready    = wave_ready_reg;
    assign busy          = (state_reg != IDLE);
    assign frame_overrun = overrun_reg;

endmodule

// File: tb/tb_frame_ctrl.sv
// Directed bench for frame_ctrl: a default-size instance for position, fill,
// overrun and reset behaviour, plus a 16-wide instance for the offset wrap.
module tb_frame_ctrl;

    logic vclock = 1'b0;
    logic reset = 1'b1;
    logic vsync = 1'b0, up = 1'b0, down = 1'b0, disp_sel = 1'b0;
    logic vsync_s = 1'b0, disp_sel_s = 1'b0, idle_in = 1'b0;

    logic [10:0] p_offset, p_offset_s;
    logic [9:0]  p_vpos, p_vpos_s, wave_index, wave_index_s, wave_data, wave_data_s;
    logic        wave_we, wave_ready, busy, frame_overrun;
    logic        wave_we_s, wave_ready_s, busy_s, frame_overrun_s;

    int n_checks = 0;
    int n_err = 0;

    always #5 vclock = ~vclock;

    frame_ctrl dut (
        .vclock(vclock), .reset(reset), .vsync(vsync), .up(up), .down(down),
        .disp_sel(disp_sel), .p_offset(p_offset), .p_vpos(p_vpos),
        .wave_index(wave_index), .wave_data(wave_data), .wave_we(wave_we),
        .wave_ready(wave_ready), .busy(busy), .frame_overrun(frame_overrun)
    );

    frame_ctrl #(.SCREEN_WIDTH(16)) dut_s (
        .vclock(vclock), .reset(reset), .vsync(vsync_s), .up(idle_in), .down(idle_in),
        .disp_sel(disp_sel_s), .p_offset(p_offset_s), .p_vpos(p_vpos_s),
        .wave_index(wave_index_s), .wave_data(wave_data_s), .wave_we(wave_we_s),
        .wave_ready(wave_ready_s), .busy(busy_s), .frame_overrun(frame_overrun_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic pu, input logic pd);
        up = pu;
        down = pd;
        @(negedge vclock);
        up = 1'b0;
        down = 1'b0;
        @(negedge vclock);
    endtask

    // One full frame on the default instance. ovr_at: write number at which a
    // stray vsync edge is injected (-1 for none). up_in_upd: press up during UPDATE.
    task automatic run_frame(input logic sel, input int ovr_at, input logic up_in_upd,
                             input logic [10:0] exp_off, input logic [9:0] exp_vp);
        int writes;
        int bad;
        int cyc;
        logic [9:0] exp_d;
        disp_sel = sel;
        vsync = 1'b1;
        @(negedge vclock);
        vsync = 1'b0;
        chk("upd_busy", 32'(busy), 32'd1);
        chk("upd_ready", 32'(wave_ready), 32'd0);
        if (up_in_upd) up = 1'b1;
        @(negedge vclock);
        up = 1'b0;
        chk("offset", 32'(p_offset), 32'(exp_off));
        chk("vpos", 32'(p_vpos), 32'(exp_vp));
        writes = 0;
        bad = 0;
        cyc = 0;
        while (wave_we && cyc < 2048) begin
            exp_d = sel ? 10'(writes + int'(exp_off[9:0])) : 10'd384;
            if (wave_index != 10'(writes)) bad++;
            if (wave_data != exp_d) bad++;
            vsync = (writes == ovr_at);
            if (writes == 300) disp_sel = ~sel;
            writes++;
            cyc++;
            @(negedge vclock);
        end
        vsync = 1'b0;
        chk("writes", 32'(writes), 32'd1024);
        chk("wdata_bad", 32'(bad), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_ready", 32'(wave_ready), 32'd0);
        @(negedge vclock);
        chk("idle_ready", 32'(wave_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        $display("frame sel=%0d off=%0d vpos=%0d writes=%0d ovr=%0d",
                 sel, p_offset, p_vpos, writes, frame_overrun);
    endtask

    task automatic run_small(input logic sel, input logic [10:0] exp_off);
        int writes;
        int bad;
        int cyc;
        logic [9:0] exp_d;
        disp_sel_s = sel;
        vsync_s = 1'b1;
        @(negedge vclock);
        vsync_s = 1'b0;
        @(negedge vclock);
        chk("s_offset", 32'(p_offset_s), 32'(exp_off));
        writes = 0;
        bad = 0;
        cyc = 0;
        while (wave_we_s && cyc < 64) begin
            exp_d = sel ? 10'(writes + int'(exp_off[9:0])) : 10'd384;
            if (wave_index_s != 10'(writes)) bad++;
            if (wave_data_s != exp_d) bad++;
            writes++;
            cyc++;
            @(negedge vclock);
        end
        chk("s_writes", 32'(writes), 32'd16);
        chk("s_wdata_bad", 32'(bad), 32'd0);
        @(negedge vclock);
        chk("s_ready", 32'(wave_ready_s), 32'd1);
        $display("small frame sel=%0d off=%0d writes=%0d", sel, p_offset_s, writes);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        repeat (3) @(negedge vclock);
        chk("rst_offset", 32'(p_offset), 32'd0);
        chk("rst_vpos", 32'(p_vpos), 32'd384);
        chk("rst_index", 32'(wave_index), 32'd0);
        chk("rst_we", 32'(wave_we), 32'd0);
        chk("rst_ready", 32'(wave_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(frame_overrun), 32'd0);
        reset = 1'b0;
        @(negedge vclock);

        // Offset wrap on the narrow instance: 15 flat frames, then a ramp at offset 0.
        for (int k = 1; k < 16; k++) run_small(1'b0, 11'(k));
        run_small(1'b1, 11'd0);

        // Flat profile after reset.
        run_frame(1'b0, -1, 1'b0, 11'd1, 10'd384);
        // Up steps with saturation at 0.
        press(1'b1, 1'b0); run_frame(1'b0, -1, 1'b0, 11'd2, 10'd284);
        press(1'b1, 1'b0); run_frame(1'b0, -1, 1'b0, 11'd3, 10'd184);
        press(1'b1, 1'b0); run_frame(1'b0, -1, 1'b0, 11'd4, 10'd84);
        press(1'b1, 1'b0); run_frame(1'b0, -1, 1'b0, 11'd5, 10'd0);
        press(1'b1, 1'b0); run_frame(1'b0, -1, 1'b0, 11'd6, 10'd0);
        // Down steps with saturation at 767.
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd7, 10'd100);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd8, 10'd200);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd9, 10'd300);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd10, 10'd400);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd11, 10'd500);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd12, 10'd600);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd13, 10'd700);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd14, 10'd767);
        press(1'b0, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd15, 10'd767);
        // Both pressed: no move. Three ups: a single step.
        press(1'b1, 1'b1); run_frame(1'b0, -1, 1'b0, 11'd16, 10'd767);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
        run_frame(1'b0, -1, 1'b0, 11'd17, 10'd667);
        // Edge during UPDATE carries over to the following frame.
        run_frame(1'b0, -1, 1'b1, 11'd18, 10'd667);
        run_frame(1'b0, -1, 1'b0, 11'd19, 10'd567);
        // Ramp profile with index+offset wrapping past 1023.
        run_frame(1'b1, -1, 1'b0, 11'd20, 10'd567);

        // Overrun: stray vsync at write 500.
        chk("pre_ovr", 32'(frame_overrun), 32'd0);
        run_frame(1'b1, 500, 1'b0, 11'd21, 10'd567);
        chk("ovr_set", 32'(frame_overrun), 32'd1);
        repeat (5) @(negedge vclock);
        chk("ovr_noqueue_busy", 32'(busy), 32'd0);
        chk("ovr_noqueue_off", 32'(p_offset), 32'd21);
        run_frame(1'b0, -1, 1'b0, 11'd22, 10'd567);
        chk("ovr_sticky", 32'(frame_overrun), 32'd1);

        // Reset at fill cycle 200.
        press(1'b1, 1'b0);
        disp_sel = 1'b0;
        vsync = 1'b1;
        @(negedge vclock);
        vsync = 1'b0;
        cyc = 0;
        while (!(wave_we && wave_index == 10'd200) && cyc < 2000) begin
            @(negedge vclock);
            cyc++;
        end
        chk("rst_reach", 32'(wave_index), 32'd200);
        reset = 1'b1;
        @(negedge vclock);
        chk("mid_rst_we", 32'(wave_we), 32'd0);
        chk("mid_rst_ready", 32'(wave_ready), 32'd0);
        chk("mid_rst_vpos", 32'(p_vpos), 32'd384);
        chk("mid_rst_off", 32'(p_offset), 32'd0);
        chk("mid_rst_ovr", 32'(frame_overrun), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge vclock);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready", 32'(wave_ready), 32'd0);
        $display("reset mid-fill: we=%0d vpos=%0d off=%0d", wave_we, p_vpos, p_offset);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
